// File: rtl/mastermind_disp_pkg.sv
// Shared segment codes, display FSM states and the symbol-to-segment encoder
// for the Mastermind HEX display controller. All segment codes are active-low {g..a}.
package mastermind_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  typedef enum logic {IDLE, REVEAL} disp_state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] value,
                                            input logic [3:0] max_symbol);
    logic [6:0] seg;
    seg = SEG_DASH;
    if (value <= max_symbol) begin
      case (value)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
    return seg;
  endfunction

endpackage

// File: rtl/mastermind_seg_decode.sv
// One digit of segment decode: blank wins over hidden, hidden shows a dash,
// otherwise the symbol is encoded (out-of-range symbols also show a dash).
module mastermind_seg_decode
  import mastermind_disp_pkg::*;
#(
  parameter int DIGIT_W    = 3,
  parameter int MAX_SYMBOL = 5
) (
  input  logic [DIGIT_W-1:0] sym_i,
  input  logic               visible_i,
  input  logic               blank_i,
  output logic [6:0]         seg_o
);

  always_comb begin
    if (blank_i)         seg_o = SEG_BLANK;
    else if (!visible_i) seg_o = SEG_DASH;
    else                 seg_o = seg_encode(4'(sym_i), 4'(MAX_SYMBOL));
  end

endmodule

// File: rtl/mastermind_hex_display.sv
// Registered seven-segment controller: latches symbols via valid/ready, blinks
// masked digits, and runs a timed leftmost-first reveal of the secret code.
module mastermind_hex_display
  import mastermind_disp_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_W     = 3,
  parameter int MAX_SYMBOL  = 5,
  parameter int BLINK_HALF  = 25_000_000,
  parameter int REVEAL_STEP = 50_000_000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]         blink_mask_i,
  input  logic                          reveal_start_i,
  output logic                          reveal_done_o,
  output logic [7*NUM_DIGITS-1:0]       hex_o
);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("NUM_DIGITS must be in 1..8");
  end
  if (DIGIT_W < 1 || DIGIT_W > 4) begin : g_bad_digit_w
    $error("DIGIT_W must be in 1..4");
  end
  if (MAX_SYMBOL < 0 || MAX_SYMBOL > 9 || MAX_SYMBOL >= (1 << DIGIT_W)) begin : g_bad_max_symbol
    $error("MAX_SYMBOL must be <= 9 and < 2**DIGIT_W");
  end
  if (BLINK_HALF < 1) begin : g_bad_blink_half
    $error("BLINK_HALF must be >= 1");
  end
  if (REVEAL_STEP < 1) begin : g_bad_reveal_step
    $error("REVEAL_STEP must be >= 1");
  end

  localparam int SW = (REVEAL_STEP > 1) ? $clog2(REVEAL_STEP) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int RW = $clog2(NUM_DIGITS + 1);

  localparam logic [SW-1:0]      STEP_LAST  = SW'(REVEAL_STEP - 1);
  localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [RW-1:0]      RCNT_END   = RW'(NUM_DIGITS);
  localparam logic [DIGIT_W-1:0] RST_SYM    = DIGIT_W'(MAX_SYMBOL + 1);

  disp_state_t                         state_q;
  logic [RW-1:0]                       rcnt_q, rcnt_d;
  logic [SW-1:0]                       step_q, step_base;
  logic [BW-1:0]                       bcnt_q;
  logic                                phase_q, ready_q, done_q, unset_q;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  sym_q;
  logic [NUM_DIGITS-1:0]               mask_q;
  logic [NUM_DIGITS-1:0][6:0]          seg_w;
  logic [NUM_DIGITS-1:0][6:0]          hex_q;
  logic [NUM_DIGITS-1:0]               vis, blank;
  logic                                load_acc, start_acc, counting, wrap, bwrap;

  // The start cycle itself counts as step 0, so rcnt reaches k exactly
  // k*REVEAL_STEP cycles after reveal_start.
  always_comb begin
    load_acc  = load_valid_i && ready_q;
    start_acc = reveal_start_i && (state_q == IDLE);
    counting  = start_acc || (state_q == REVEAL && rcnt_q != RCNT_END);
    step_base = start_acc ? '0 : step_q;
    wrap      = counting && (step_base == STEP_LAST);
    bwrap     = (bcnt_q == BLINK_LAST);
    rcnt_d    = start_acc ? '0 : rcnt_q;
    if (wrap) rcnt_d = rcnt_d + RW'(1);
  end

  always_comb begin
    vis   = '0;
    blank = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      vis[i]   = !unset_q && ((state_q == IDLE) || ((int'(rcnt_q) + i) >= NUM_DIGITS));
      blank[i] = (state_q == IDLE) && !phase_q && mask_q[i];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    mastermind_seg_decode #(
      .DIGIT_W   (DIGIT_W),
      .MAX_SYMBOL(MAX_SYMBOL)
    ) u_dec (
      .sym_i    (sym_q[g]),
      .visible_i(vis[g]),
      .blank_i  (blank[g]),
      .seg_o    (seg_w[g])
    );
  end

  // unset_q keeps digits dashed until the first load even when MAX_SYMBOL+1
  // does not fit in DIGIT_W bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      rcnt_q  <= '0;
      step_q  <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      unset_q <= 1'b1;
      sym_q   <= {NUM_DIGITS{RST_SYM}};
      mask_q  <= '0;
      hex_q   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      hex_q  <= seg_w;
      rcnt_q <= rcnt_d;
      done_q <= wrap && (rcnt_d == RCNT_END);
      if (counting) step_q <= wrap ? '0 : step_base + SW'(1);
      if (load_acc) begin
        sym_q   <= digits_i;
        mask_q  <= blink_mask_i;
        unset_q <= 1'b0;
      end
      if (load_acc || bwrap) bcnt_q <= '0;
      else                   bcnt_q <= bcnt_q + BW'(1);
      if (load_acc)   phase_q <= 1'b1;
      else if (bwrap) phase_q <= ~phase_q;
      case (state_q)
        IDLE: if (start_acc) begin
          state_q <= REVEAL;
          ready_q <= 1'b0;
        end
        REVEAL: if (rcnt_q == RCNT_END) begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready_o  = ready_q;
  assign reveal_done_o = done_q;
  assign hex_o         = hex_q;

endmodule

// File: doc/mastermind_hex_display.md
# mastermind_hex_display

Registered, parametrised seven-segment display controller for the Mastermind board. It drives NUM_DIGITS active-low HEX displays from latched symbol values. It adds a valid/ready load handshake, per-digit blinking, and a timed left-to-right "reveal" sequence used to uncover the secret code at game end. It sits between the game FSM and the board HEX pins, replacing the purely combinational per-digit decoder.

## Interface
- NUM_DIGITS, 4, number of HEX displays driven (1..8)
- DIGIT_W, 3, bits per symbol value (1..4)
- MAX_SYMBOL, 5, largest valid symbol; values above it display dash (must be <= 9 and < 2**DIGIT_W)
- BLINK_HALF, 25_000_000, clock cycles per blink half-period (>= 1)
- REVEAL_STEP, 50_000_000, clock cycles between successive digit reveals (>= 1)

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- load_valid  in  1  request to latch digits and blink_mask
- load_ready  out  1  high when a load is accepted this cycle
- digits  in  NUM_DIGITS*DIGIT_W  packed symbols; digit i = bits [i*DIGIT_W +: DIGIT_W]; digit 0 = rightmost (HEX0)
- blink_mask  in  NUM_DIGITS  bit i set = digit i blinks
- reveal_start  in  1  single-cycle strobe: begin reveal sequence
- reveal_done  out  1  single-cycle pulse when the last digit is revealed
- hex  out  7*NUM_DIGITS  active-low segments {g..a}; digit i = bits [i*7 +: 7]

## Operation
- Encoding, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111, blank=1111111.
- State machine states are IDLE and REVEAL.
  - IDLE: load_ready=1. A load is accepted when load_valid && load_ready; it latches digits and blink_mask.
  - reveal_start in IDLE moves to REVEAL, with rcnt=0 and step counter=0.
  - REVEAL: load_ready=0, load_valid is ignored, and further reveal_start strobes are ignored.
  - In REVEAL, the step counter counts 0..REVEAL_STEP-1. At wrap, rcnt increments.
  - When rcnt reaches NUM_DIGITS, reveal_done pulses that same cycle and the FSM returns to IDLE.
- Visibility in REVEAL: digit i shows its symbol if i >= NUM_DIGITS-rcnt, otherwise dash. Digits are therefore uncovered from the highest index (leftmost) down to digit 0.
- IDLE shows all digits, with blinking applied.
- Blink: a free-running prescaler toggles phase every BLINK_HALF cycles.
  - When phase=0, each digit with its mask bit set shows blank.
  - When phase=1, every digit is shown normally.
  - An accepted load restarts the prescaler and sets phase=1.
  - Blinking is suppressed during REVEAL.
- Simultaneous load_valid and reveal_start in IDLE: the load is accepted, and the reveal starts on the newly latched data.
- A latched symbol greater than MAX_SYMBOL shows dash.

## Timing
- Reset values:
  - hex: all ones (blank)
  - load_ready: 1
  - reveal_done: 0
  - state: IDLE
  - latched digits: all MAX_SYMBOL+1, so digits show dash after reset
  - blink_mask: 0
  - phase: 1
  - rcnt and both counters: 0
- hex is registered: it reflects latched data and state one cycle after they change.
  - A load accepted in cycle N appears on hex at N+2: latch at the edge ending N, output register at the next edge.
- Reveal timing, for reveal_start in cycle S:
  - The first digit appears on hex at S+REVEAL_STEP+1.
  - Each later digit follows REVEAL_STEP cycles after the previous one.
  - reveal_done is asserted in the cycle rcnt becomes NUM_DIGITS, which is S+NUM_DIGITS*REVEAL_STEP.
  - load_ready returns high in the following cycle.
- reset mid-REVEAL: the next cycle is IDLE with reset values; no reveal_done pulse.
- Counters never overflow: each counter is sized as clog2 of its terminal count and wraps exactly at terminal-1.

## Structure
- Package mastermind_disp_pkg holds:
  - SEG_BLANK and SEG_DASH constants, and the digit-code constants 0..9
  - the disp_state_t enum (IDLE, REVEAL)
  - function seg_encode(value, max_symbol)
- Sub-module mastermind_seg_decode: combinational; inputs are one symbol, a visible flag and a blank flag; output is 7 segment bits. It is instantiated NUM_DIGITS times via generate.
- The top level holds the FSM, the blink prescaler, the step counter, rcnt, the latches and the output register.
- Parameter legality is checked with elaboration-time assertions.

## Test plan
Scenarios 2 to 5 use NUM_DIGITS=4, BLINK_HALF=4 and REVEAL_STEP=3.
- Reset then idle:
  - hex=28'hFFFFFFF in the reset cycle.
  - Two cycles later, each digit = 0111111 (dash); load_ready=1.
- Load digits={3'd5,3'd0,3'd3,3'd1} with mask 0:
  - 2 cycles later: HEX3=0010010, HEX2=1000000, HEX1=0110000, HEX0=1111001.
  - A value of 3'd7 on any digit shows dash.
- Load with blink_mask=4'b0001:
  - HEX0 alternates between its symbol and 1111111 every 4 cycles, starting with the symbol visible.
  - HEX1..HEX3 remain steady.
- reveal_start after loading {2,4,1,0}:
  - load_ready=0 for 12 cycles.
  - HEX3 is uncovered first at S+4, then HEX2, HEX1 and HEX0 follow at 3-cycle spacing.
  - reveal_done pulses exactly once at S+12; a load_valid during REVEAL is ignored.
- Same-cycle load_valid with reveal_start: the reveal uncovers the newly loaded values.
- rst asserted mid-REVEAL: next cycle is IDLE, load_ready=1, no reveal_done, and digits go back to dash.
